rr_mux_arbiter: RTL

- Round-robin arbiter and sequencer that shares one output channel among 2**N requesters.
- Chooses a requester, drives the select, captures that requester's DATAW-bit data lane into a holding register, and presents it on a valid/ready output handshake.
- Sits between the coin/item request sources and the single downstream consumer, such as the display or dispense logic.
- Guarantees each requester is served in fair rotation.

---
 rtl/rr_mux_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter sharing one valid/ready output among 2**N lanes
module rr_mux_arbiter #(
   parameter int N     = 2,
   parameter int DATAW = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [2**N-1:0]           req,
   input  logic [(2**N)*DATAW-1:0]   data,
   output logic [2**N-1:0]           grant,
   output logic [N-1:0]              sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATAW-1:0]          out_data
);

   localparam int NREQ = 2**N;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     ptr_q;
   logic [N-1:0]     win;
   logic [N-1:0]     cand;
   logic             found;
   logic             load;
   logic             done;

   // Search starts at ptr_q; N-bit addition wraps the index for free.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_q + N'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      grant     = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done    = 1'b1;
               grant   = NREQ'(1) << sel;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel      <= '0;
         out_data <= '0;
         ptr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            sel      <= win;
            out_data <= data[win*DATAW +: DATAW];
         end
         // The lane just served drops to lowest priority.
         if (done)
            ptr_q <= sel + 1'b1;
      end
   end

endmodule
